// File: rtl/ppu_pkg.sv
// Shared PPU definitions: sprite entry layout, scan FSM encoding and a constant clog2.
// Entry layout msb->lsb is {enable, y, x, attr}; offsets are derived from the field widths.
package ppu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int entry_w(input int y_w, input int x_w, input int attr_w);
    return 1 + y_w + x_w + attr_w;
  endfunction

  function automatic int x_lsb(input int attr_w);
    return attr_w;
  endfunction

  function automatic int y_lsb(input int x_w, input int attr_w);
    return attr_w + x_w;
  endfunction

  function automatic int en_bit(input int y_w, input int x_w, input int attr_w);
    return attr_w + x_w + y_w;
  endfunction

endpackage

// File: rtl/sprite_slot_match.sv
// One slot's horizontal test: dx = display_x - slot_x, range check against SPR_W, mirrored column.
// Purely combinational, zero latency; no flow control.
module sprite_slot_match
  import ppu_pkg::*;
#(
  parameter int X_W   = 12,
  parameter int SPR_W = 64,
  parameter int RX_W  = clog2(SPR_W)
) (
  input  logic [X_W-1:0]  display_x,
  input  logic [X_W-1:0]  slot_x,
  input  logic            mirror,
  output logic            hit,
  output logic [RX_W-1:0] rel_x
);

  localparam logic signed [X_W:0] SPR_W_S = (X_W+1)'(SPR_W);

  logic signed [X_W:0] dx;

  assign dx  = $signed({1'b0, display_x}) - $signed({1'b0, slot_x});
  assign hit = !dx[X_W] && (dx < SPR_W_S);

  // SPR_W is a power of two, so SPR_W-1-dx is the bitwise inverse of dx's low bits.
  assign rel_x = mirror ? ~dx[RX_W-1:0] : dx[RX_W-1:0];

endmodule

// File: rtl/sprite_line_engine.sv
// Per-scanline sprite engine: hblank scan of the active table into slots, then per-pixel priority select.
// Pixel outputs lag display_x by 1 cycle; front list updates N_SPRITES+2 cycles after line_start; no backpressure.
module sprite_line_engine
  import ppu_pkg::*;
#(
  parameter int N_SPRITES    = 8,
  parameter int MAX_PER_LINE = 4,
  parameter int SPR_W        = 64,
  parameter int SPR_H        = 210,
  parameter int X_W          = 12,
  parameter int Y_W          = 11,
  parameter int ATTR_W       = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            tbl_wr_en,
  input  logic [clog2(N_SPRITES)-1:0]     tbl_wr_idx,
  input  logic [1+Y_W+X_W+ATTR_W-1:0]     tbl_wr_data,
  input  logic                            commit,
  input  logic                            line_start,
  input  logic [Y_W-1:0]                  next_row,
  input  logic [X_W-1:0]                  display_x,
  output logic                            hit,
  output logic [ATTR_W-1:0]               hit_attr,
  output logic [clog2(SPR_W)-1:0]         rel_x,
  output logic [clog2(SPR_H)-1:0]         rel_y,
  output logic                            overflow,
  output logic                            scan_busy
);

  localparam int IDX_W = clog2(N_SPRITES);
  localparam int ENT_W = entry_w(Y_W, X_W, ATTR_W);
  localparam int RX_W  = clog2(SPR_W);
  localparam int RY_W  = clog2(SPR_H);
  localparam int CNT_W = clog2(MAX_PER_LINE + 1);
  localparam int X_LSB = x_lsb(ATTR_W);
  localparam int Y_LSB = y_lsb(X_W, ATTR_W);
  localparam int EN    = en_bit(Y_W, X_W, ATTR_W);
  localparam logic signed [Y_W:0] SPR_H_S = (Y_W+1)'(SPR_H);

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [ATTR_W-1:0] attr;
    logic [RY_W-1:0]   rel_y;
  } slot_t;

  logic [ENT_W-1:0] shadow [N_SPRITES];
  logic [ENT_W-1:0] active [N_SPRITES];
  logic             commit_pend;
  logic             copy_now;

  scan_state_t      state, state_nxt;
  logic             start, step, publish;
  logic [IDX_W-1:0] idx;
  logic [Y_W-1:0]   row;
  slot_t            back  [MAX_PER_LINE];
  slot_t            front [MAX_PER_LINE];
  logic [CNT_W-1:0] back_cnt, front_cnt;
  logic             back_ovf;

  logic [ENT_W-1:0]    cur;
  logic signed [Y_W:0] dy;
  logic                match;
  slot_t               cand;

  // A commit that arrives mid-scan waits until the FSM is back in IDLE.
  assign copy_now = (commit || commit_pend) && (state == ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pend <= 1'b0;
    end else begin
      if (tbl_wr_en) shadow[tbl_wr_idx] <= tbl_wr_data;
      if (copy_now) begin
        for (int i = 0; i < N_SPRITES; i++)
          active[i] <= (tbl_wr_en && tbl_wr_idx == IDX_W'(i)) ? tbl_wr_data : shadow[i];
      end
      commit_pend <= !copy_now && (commit || commit_pend);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    publish   = 1'b0;
    case (state)
      ST_IDLE: if (line_start) begin
        state_nxt = ST_SCAN;
        start     = 1'b1;
      end
      ST_SCAN: if (line_start) begin
        start = 1'b1;
      end else begin
        step = 1'b1;
        if (idx == IDX_W'(N_SPRITES - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: if (line_start) begin
        state_nxt = ST_SCAN;
        start     = 1'b1;
      end else begin
        publish   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign scan_busy = (state != ST_IDLE);

  assign cur   = active[idx];
  assign dy    = $signed({1'b0, row}) - $signed({1'b0, cur[Y_LSB +: Y_W]});
  assign match = cur[EN] && !dy[Y_W] && (dy < SPR_H_S);
  assign cand  = '{x: cur[X_LSB +: X_W], attr: cur[ATTR_W-1:0], rel_y: dy[RY_W-1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      row       <= '0;
      back_cnt  <= '0;
      back_ovf  <= 1'b0;
      front_cnt <= '0;
      overflow  <= 1'b0;
      for (int s = 0; s < MAX_PER_LINE; s++) begin
        back[s]  <= '0;
        front[s] <= '0;
      end
    end else begin
      if (start) begin
        idx      <= '0;
        row      <= next_row;
        back_cnt <= '0;
        back_ovf <= 1'b0;
        for (int s = 0; s < MAX_PER_LINE; s++) back[s] <= '0;
      end else if (step) begin
        idx <= idx + 1'b1;
        if (match) begin
          if (back_cnt < CNT_W'(MAX_PER_LINE)) begin
            for (int s = 0; s < MAX_PER_LINE; s++)
              if (back_cnt == CNT_W'(s)) back[s] <= cand;
            back_cnt <= back_cnt + 1'b1;
          end else begin
            back_ovf <= 1'b1;
          end
        end
      end
      if (publish) begin
        front     <= back;
        front_cnt <= back_cnt;
        overflow  <= back_ovf;
      end
    end
  end

  logic [MAX_PER_LINE-1:0] slot_hit;
  logic [RX_W-1:0]         slot_rx [MAX_PER_LINE];

  for (genvar s = 0; s < MAX_PER_LINE; s++) begin : g_slot
    sprite_slot_match #(.X_W(X_W), .SPR_W(SPR_W), .RX_W(RX_W)) u_match (
      .display_x (display_x),
      .slot_x    (front[s].x),
      .mirror    (front[s].attr[ATTR_W-1]),
      .hit       (slot_hit[s]),
      .rel_x     (slot_rx[s])
    );
  end

  logic              px_hit;
  logic [ATTR_W-1:0] px_attr;
  logic [RX_W-1:0]   px_rx;
  logic [RY_W-1:0]   px_ry;

  // Walk from the lowest-priority slot up so slot 0 overrides everything.
  always_comb begin
    px_hit  = 1'b0;
    px_attr = '0;
    px_rx   = '0;
    px_ry   = '0;
    for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
      if (slot_hit[s] && (CNT_W'(s) < front_cnt)) begin
        px_hit  = 1'b1;
        px_attr = front[s].attr;
        px_rx   = slot_rx[s];
        px_ry   = front[s].rel_y;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit      <= 1'b0;
      hit_attr <= '0;
      rel_x    <= '0;
      rel_y    <= '0;
    end else begin
      hit      <= px_hit;
      hit_attr <= px_attr;
      rel_x    <= px_rx;
      rel_y    <= px_ry;
    end
  end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Bench for sprite_line_engine: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a table-level model of scan results and pixel selection.
module tb_sprite_line_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tbl_wr_en = 1'b0;
  logic [2:0]  tbl_wr_idx = '0;
  logic [31:0] tbl_wr_data = '0;
  logic        commit = 1'b0;
  logic        line_start = 1'b0;
  logic [10:0] next_row = '0;
  logic [11:0] display_x = '0;
  logic        hit;
  logic [7:0]  hit_attr;
  logic [5:0]  rel_x;
  logic [7:0]  rel_y;
  logic        overflow;
  logic        scan_busy;

  int vectors = 0;
  int miscompares = 0;

  sprite_line_engine dut (
    .clock       (clock),
    .reset       (reset),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_idx  (tbl_wr_idx),
    .tbl_wr_data (tbl_wr_data),
    .commit      (commit),
    .line_start  (line_start),
    .next_row    (next_row),
    .display_x   (display_x),
    .hit         (hit),
    .hit_attr    (hit_attr),
    .rel_x       (rel_x),
    .rel_y       (rel_y),
    .overflow    (overflow),
    .scan_busy   (scan_busy)
  );

  always #5 clock = ~clock;

  // Model: tables as arrays, a scan is "age" cycles old and resolves to a filtered list when it completes.
  logic [31:0] m_shadow [8];
  logic [31:0] m_active [8];
  bit          m_pend = 0;
  int          m_age = -1;
  int          m_row = 0;
  int          m_fcnt = 0;
  int          m_fx [4];
  logic [7:0]  m_fattr [4];
  int          m_fry [4];
  bit          m_fovf = 0;
  bit          m_busy_old;
  int          m_dx, m_dy;
  bit          e_hit = 0;
  int          e_attr = 0, e_rx = 0, e_ry = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_pend = 0; m_age = -1; m_row = 0; m_fcnt = 0; m_fovf = 0;
      e_hit = 0; e_attr = 0; e_rx = 0; e_ry = 0;
    end else begin
      e_hit = 0; e_attr = 0; e_rx = 0; e_ry = 0;
      for (int s = 0; s < m_fcnt; s++) begin
        m_dx = int'(display_x) - m_fx[s];
        if (!e_hit && m_dx >= 0 && m_dx < 64) begin
          e_hit  = 1;
          e_attr = int'(m_fattr[s]);
          e_rx   = m_fattr[s][7] ? 63 - m_dx : m_dx;
          e_ry   = m_fry[s];
        end
      end
      m_busy_old = (m_age >= 0);
      if (line_start) begin
        m_age = 0;
        m_row = int'(next_row);
      end else if (m_age == 8) begin
        m_fcnt = 0;
        m_fovf = 0;
        for (int i = 0; i < 8; i++) begin
          m_dy = m_row - int'(m_active[i][30:20]);
          if (m_active[i][31] && m_dy >= 0 && m_dy < 210) begin
            if (m_fcnt < 4) begin
              m_fx[m_fcnt]    = int'(m_active[i][19:8]);
              m_fattr[m_fcnt] = m_active[i][7:0];
              m_fry[m_fcnt]   = m_dy;
              m_fcnt++;
            end else begin
              m_fovf = 1;
            end
          end
        end
        m_age = -1;
      end else if (m_age >= 0) begin
        m_age++;
      end
      if ((commit || m_pend) && !m_busy_old) begin
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
        if (tbl_wr_en) m_active[tbl_wr_idx] = tbl_wr_data;
        m_pend = 0;
      end else if (commit) begin
        m_pend = 1;
      end
      if (tbl_wr_en) m_shadow[tbl_wr_idx] = tbl_wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("model_hit", 32'(hit), 32'(e_hit));
    chk("model_attr", 32'(hit_attr), e_attr);
    chk("model_rel_x", 32'(rel_x), e_rx);
    chk("model_rel_y", 32'(rel_y), e_ry);
    chk("model_overflow", 32'(overflow), 32'(m_fovf));
    chk("model_busy", 32'(scan_busy), 32'(m_age >= 0));
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wr(input int idx, input bit en, input int y, input int x, input int attr);
    tbl_wr_en   = 1'b1;
    tbl_wr_idx  = 3'(idx);
    tbl_wr_data = {en, 11'(y), 12'(x), 8'(attr)};
    tick();
    tbl_wr_en   = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic scan(input int row);
    line_start = 1'b1;
    next_row   = 11'(row);
    tick();
    line_start = 1'b0;
    repeat (12) tick();
  endtask

  task automatic pix(input int x);
    display_x = 12'(x);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_hit", 32'(hit), 0);
    chk("reset_busy", 32'(scan_busy), 0);
    chk("reset_overflow", 32'(overflow), 0);
    reset = 1'b0;
    tick();

    // Single sprite, straight sweep across its span.
    wr(0, 1, 50, 100, 8'h11);
    do_commit();
    scan(50);
    for (int x = 90; x <= 170; x++) begin
      pix(x);
      chk("sweep_hit", 32'(hit), 32'(x >= 100 && x <= 163));
      if (x >= 100 && x <= 163) begin
        chk("sweep_rel_x", 32'(rel_x), x - 100);
        chk("sweep_rel_y", 32'(rel_y), 0);
      end
    end
    pix(163);
    chk("edge_rel_x", 32'(rel_x), 63);
    chk("edge_attr", 32'(hit_attr), 8'h11);

    // Mirrored, bottom row of the sprite, then one row past it.
    wr(0, 1, 50, 100, 8'h91);
    do_commit();
    scan(259);
    pix(100);
    chk("mirror_rel_x", 32'(rel_x), 63);
    chk("mirror_rel_y", 32'(rel_y), 209);
    pix(163);
    chk("mirror_rel_x_end", 32'(rel_x), 0);
    scan(260);
    pix(100);
    chk("below_hit", 32'(hit), 0);

    // Six sprites on one row: four slots, overflow flagged.
    for (int i = 0; i < 6; i++) wr(i, 1, 20, i * 70, i + 1);
    do_commit();
    scan(20);
    chk("ovf_set", 32'(overflow), 1);
    pix(215);
    chk("ovf_slot3_attr", 32'(hit_attr), 4);
    pix(285);
    chk("ovf_slot4_hit", 32'(hit), 0);
    pix(355);
    chk("ovf_slot5_hit", 32'(hit), 0);
    scan(500);
    chk("ovf_clear", 32'(overflow), 0);

    // Overlap: lower table index wins.
    for (int i = 0; i < 8; i++) wr(i, 0, 0, 0, 0);
    wr(2, 1, 30, 10, 8'h22);
    wr(5, 1, 30, 40, 8'h55);
    do_commit();
    scan(30);
    pix(45);
    chk("prio_attr", 32'(hit_attr), 8'h22);
    chk("prio_rel_x", 32'(rel_x), 35);
    pix(80);
    chk("prio_second_attr", 32'(hit_attr), 8'h55);
    pix(110);
    chk("prio_none", 32'(hit), 0);

    // Commit (with a same-cycle write) during a scan is deferred past it.
    line_start = 1'b1;
    next_row   = 11'd30;
    tick();
    line_start = 1'b0;
    tick();
    tbl_wr_en   = 1'b1;
    tbl_wr_idx  = 3'd2;
    tbl_wr_data = {1'b1, 11'd30, 12'd200, 8'h22};
    commit      = 1'b1;
    tick();
    tbl_wr_en = 1'b0;
    commit    = 1'b0;
    repeat (12) tick();
    pix(45);
    chk("defer_old_attr", 32'(hit_attr), 8'h22);
    scan(30);
    pix(45);
    chk("defer_new_attr", 32'(hit_attr), 8'h55);
    pix(205);
    chk("defer_new_moved", 32'(hit_attr), 8'h22);
    chk("defer_new_rel_x", 32'(rel_x), 5);

    // Restart three cycles into a scan: only the second row ever reaches the front list.
    display_x  = 12'd45;
    line_start = 1'b1;
    next_row   = 11'd31;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    line_start = 1'b1;
    next_row   = 11'd500;
    for (int j = 1; j <= 11; j++) begin
      tick();
      line_start = 1'b0;
      chk("restart_hit", 32'(hit), 32'(j < 11));
      if (j < 11) chk("restart_rel_y", 32'(rel_y), 0);
    end

    // Reset in the middle of a scan clears everything at once.
    scan(30);
    pix(45);
    chk("pre_reset_hit", 32'(hit), 1);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("midreset_busy", 32'(scan_busy), 0);
    chk("midreset_hit", 32'(hit), 0);
    chk("midreset_attr", 32'(hit_attr), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    for (int c = 0; c < 3000; c++) begin
      tbl_wr_en   = ($urandom_range(0, 9) < 3);
      tbl_wr_idx  = 3'($urandom_range(0, 7));
      tbl_wr_data = {1'($urandom_range(0, 3) != 0), 11'($urandom_range(0, 300)),
                     12'($urandom_range(0, 400)), 8'($urandom)};
      commit      = ($urandom_range(0, 19) == 0);
      line_start  = ($urandom_range(0, 29) == 0);
      next_row    = 11'($urandom_range(0, 500));
      display_x   = 12'($urandom_range(0, 480));
      tick();
    end
    tbl_wr_en  = 1'b0;
    commit     = 1'b0;
    line_start = 1'b0;
    repeat (15) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
